// File: rtl/fpu_arb_pkg.sv
// Shared types for the FPU add/sub arbiter: FSM states, in-flight tag and one-hot decode.
package fpu_arb_pkg;

    localparam int SIZE_ID_MAX = 3;
    localparam int NUM_REQ_MAX = 8;

    typedef enum logic [1:0] {RUN, DRAIN, IDLE_WAIT} arb_state_e;

    typedef struct packed {
        logic                   valid;
        logic [SIZE_ID_MAX-1:0] id;
    } tag_t;

    function automatic logic [NUM_REQ_MAX-1:0] onehot_f(input logic [SIZE_ID_MAX-1:0] id);
        onehot_f     = '0;
        onehot_f[id] = 1'b1;
    endfunction

endpackage

// File: rtl/fpu_arb_tag_pipe.sv
// Requester-ID delay line that tracks each issued op through the fixed-latency FPU.
module fpu_arb_tag_pipe
    import fpu_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_d,
    output tag_t tag_q
);

    tag_t stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= tag_d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign tag_q = stage[DEPTH-1];

endmodule

// File: rtl/fpu_addsub_arbiter.sv
// Round-robin sharing of one pipelined FPU add/sub among NUM_REQ requesters with drain/flush.
// Define FPU_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no RR pointer).
module fpu_addsub_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int SIZE_DATA   = 32,
    parameter int FPU_LATENCY = 4,
    parameter int SIZE_ID     = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NUM_REQ-1:0]           i_req_valid,
    input  logic [NUM_REQ*SIZE_DATA-1:0] i_req_op_a,
    input  logic [NUM_REQ*SIZE_DATA-1:0] i_req_op_b,
    input  logic [NUM_REQ-1:0]           i_req_sub,
    output logic [NUM_REQ-1:0]           o_req_ready,
    output logic                         o_fpu_valid,
    output logic [SIZE_DATA-1:0]         o_fpu_op_a,
    output logic [SIZE_DATA-1:0]         o_fpu_op_b,
    output logic                         o_fpu_sub,
    input  logic [SIZE_DATA-1:0]         i_fpu_result,
    input  logic                         i_fpu_valid,
    output logic [NUM_REQ-1:0]           o_rsp_valid,
    output logic [SIZE_DATA-1:0]         o_rsp_data,
    input  logic                         i_flush,
    output logic                         o_idle,
    output logic                         o_err
);

    localparam int CNT_W = $clog2(FPU_LATENCY + 2);

    arb_state_e             state, state_nxt;
    logic                   grant_en, hs;
    int                     start, gnt_idx;
    logic [SIZE_ID-1:0]     gnt_id;
    logic [NUM_REQ-1:0]     grant;
    logic [SIZE_DATA-1:0]   sel_a, sel_b;
    logic                   sel_sub;
    logic [SIZE_ID_MAX-1:0] iss_id;
    tag_t                   tag_in, tag_out;
    logic [NUM_REQ_MAX-1:0] rsp_oh;
    logic [CNT_W-1:0]       inflight;

    // Grants are held off during reset so o_req_ready reads 0 even with requests asserted.
    assign grant_en = i_rst_n && (state == RUN) && !i_flush;

`ifdef FPU_ARB_FIXED_PRIO_EN
    assign start = 0;
`else
    logic [SIZE_ID-1:0] rr_ptr;
    assign start = int'(rr_ptr);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                rr_ptr <= '0;
        else if (state == IDLE_WAIT) rr_ptr <= '0;
        else if (hs)                 rr_ptr <= SIZE_ID'((gnt_idx + 1) % NUM_REQ);
    end
`endif

    always_comb begin
        grant   = '0;
        gnt_idx = 0;
        hs      = 1'b0;
        sel_a   = '0;
        sel_b   = '0;
        sel_sub = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!hs && grant_en && i_req_valid[(start + i) % NUM_REQ]) begin
                hs      = 1'b1;
                gnt_idx = (start + i) % NUM_REQ;
            end
        end
        if (hs) begin
            grant[gnt_idx] = 1'b1;
            sel_a          = i_req_op_a[gnt_idx*SIZE_DATA +: SIZE_DATA];
            sel_b          = i_req_op_b[gnt_idx*SIZE_DATA +: SIZE_DATA];
            sel_sub        = i_req_sub[gnt_idx];
        end
    end

    assign o_req_ready = grant;
    assign gnt_id      = SIZE_ID'(gnt_idx);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_fpu_valid <= 1'b0;
            o_fpu_op_a  <= '0;
            o_fpu_op_b  <= '0;
            o_fpu_sub   <= 1'b0;
            iss_id      <= '0;
        end else begin
            o_fpu_valid <= hs;
            if (hs) begin
                o_fpu_op_a <= sel_a;
                o_fpu_op_b <= sel_b;
                o_fpu_sub  <= sel_sub;
                iss_id     <= SIZE_ID_MAX'(gnt_id);
            end
        end
    end

    // Fed from the issue register so the last stage lines up with i_fpu_result.
    assign tag_in = '{valid: o_fpu_valid, id: iss_id};

    fpu_arb_tag_pipe #(.DEPTH(FPU_LATENCY)) u_tag_pipe (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .tag_d (tag_in),
        .tag_q (tag_out)
    );

    assign rsp_oh = onehot_f(tag_out.id);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
            o_err       <= 1'b0;
        end else begin
            o_rsp_valid <= tag_out.valid ? NUM_REQ'(rsp_oh) : '0;
            if (tag_out.valid) o_rsp_data <= i_fpu_result;
            if (i_fpu_valid != tag_out.valid) o_err <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            inflight <= '0;
        end else begin
            case ({hs, tag_out.valid})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= RUN;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:       if (i_flush)         state_nxt = DRAIN;
            DRAIN:     if (inflight == '0)  state_nxt = IDLE_WAIT;
            IDLE_WAIT: if (!i_flush)        state_nxt = RUN;
            default:                        state_nxt = RUN;
        endcase
    end

    assign o_idle = (state == RUN) && (inflight == '0);

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Directed bench for fpu_addsub_arbiter with a 4-cycle FPU model and a response monitor.
module tb_fpu_addsub_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int L = 4;

    logic           i_clk, i_rst_n;
    logic [N-1:0]   i_req_valid, i_req_sub;
    logic [N*W-1:0] i_req_op_a, i_req_op_b;
    logic [N-1:0]   o_req_ready, o_rsp_valid;
    logic           o_fpu_valid, o_fpu_sub, i_fpu_valid, i_flush, o_idle, o_err;
    logic [W-1:0]   o_fpu_op_a, o_fpu_op_b, i_fpu_result, o_rsp_data;

    fpu_addsub_arbiter #(.NUM_REQ(N), .SIZE_DATA(W), .FPU_LATENCY(L), .SIZE_ID(2)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .i_req_op_a(i_req_op_a), .i_req_op_b(i_req_op_b),
        .i_req_sub(i_req_sub), .o_req_ready(o_req_ready),
        .o_fpu_valid(o_fpu_valid), .o_fpu_op_a(o_fpu_op_a), .o_fpu_op_b(o_fpu_op_b),
        .o_fpu_sub(o_fpu_sub), .i_fpu_result(i_fpu_result), .i_fpu_valid(i_fpu_valid),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
        .i_flush(i_flush), .o_idle(o_idle), .o_err(o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] fpu_f(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !s) return 32'h4040_0000;
        return a ^ {b[15:0], b[31:16]} ^ {31'd0, s};
    endfunction

    // FPU model: result appears L cycles after the issue strobe.
    logic [L-1:0] mv;
    logic [31:0]  md [L];
    logic         fpu_drop;
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mv <= '0;
        end else begin
            mv    <= {mv[L-2:0], o_fpu_valid};
            md[0] <= fpu_f(o_fpu_op_a, o_fpu_op_b, o_fpu_sub);
            for (int k = 1; k < L; k++) md[k] <= md[k-1];
        end
    end
    assign i_fpu_valid  = mv[L-1] & ~fpu_drop;
    assign i_fpu_result = md[L-1];

    typedef struct {
        logic [N-1:0] oh;
        logic [31:0]  data;
        int           cyc;
    } rsp_t;
    rsp_t rsp_q[$];
    int   cyc_cnt = 0;
    always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;
    always @(negedge i_clk) if (o_rsp_valid != '0) rsp_q.push_back('{o_rsp_valid, o_rsp_data, cyc_cnt});

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk); #1;
    endtask

    initial begin
        int t;
        logic [N-1:0] exp;
        i_rst_n = 1'b0; i_req_valid = '0; i_req_sub = '0; i_flush = 1'b0; fpu_drop = 1'b0;
        i_req_op_a = '0; i_req_op_b = '0;
        for (int k = 0; k < N; k++) begin
            i_req_op_a[k*W +: W] = 32'h4100_0000 + k * 32'h0010_0000;
            i_req_op_b[k*W +: W] = 32'h3F00_0000 + k;
            i_req_sub[k]         = k[0];
        end
        i_req_valid = '1;
        repeat (2) @(negedge i_clk);
        chk("rst_ready", o_req_ready, 0);
        chk("rst_fpu_valid", o_fpu_valid, 0);
        chk("rst_fpu_ops", {o_fpu_op_a, o_fpu_op_b, o_fpu_sub}, 0);
        chk("rst_rsp", {o_rsp_valid, o_rsp_data}, 0);
        chk("rst_err_idle", {o_err, o_idle}, 2'b01);
        i_req_valid = '0;
        cyc(); i_rst_n = 1'b1;

        // Burst: all four requesters for 8 cycles
        rsp_q.delete();
        for (int c = 0; c < 8; c++) begin
            cyc(); i_req_valid = '1;
            @(negedge i_clk);
            chk("burst_grant", o_req_ready, 64'(1) << (c % 4));
        end
        cyc(); i_req_valid = '0;
        repeat (10) cyc();
        chk("burst_count", rsp_q.size(), 8);
        for (int j = 0; j < rsp_q.size(); j++) begin
            chk("burst_id", rsp_q[j].oh, 64'(1) << (j % 4));
            chk("burst_data", rsp_q[j].data,
                fpu_f(32'h4100_0000 + (j % 4) * 32'h0010_0000, 32'h3F00_0000 + (j % 4), j[0]));
            chk("burst_spacing", rsp_q[j].cyc - rsp_q[0].cyc, j);
        end

        // Single op on requester 0 with exact-cycle checks
        i_req_op_a[0 +: W] = 32'h3F80_0000;
        i_req_op_b[0 +: W] = 32'h4000_0000;
        i_req_sub[0]       = 1'b0;
        cyc(); i_req_valid = 4'b0001;
        @(negedge i_clk); chk("single_ready", o_req_ready, 4'b0001);
        cyc(); i_req_valid = '0;
        @(negedge i_clk);
        chk("single_issue", {o_fpu_valid, o_fpu_op_a, o_fpu_op_b, o_fpu_sub},
            {1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0});
        chk("single_busy", o_idle, 0);
        repeat (4) cyc();
        @(negedge i_clk); chk("single_early", o_rsp_valid, 0);
        cyc();
        @(negedge i_clk);
        chk("single_rsp", {o_rsp_valid, o_rsp_data}, {4'b0001, 32'h4040_0000});
        chk("single_err", o_err, 0);
        cyc();
        @(negedge i_clk); chk("single_idle", {o_idle, o_rsp_valid}, {1'b1, 4'b0000});

        // Flush with 3 ops in flight and requests still pending
        rsp_q.delete();
        for (int c = 0; c < 3; c++) begin cyc(); i_req_valid = '1; end
        cyc(); i_flush = 1'b1;
        @(negedge i_clk); chk("flush_mask", o_req_ready, 0);
        cyc(); i_flush = 1'b0;
        t = 4;
        @(negedge i_clk);
        while (o_req_ready == '0 && t < 30) begin
            cyc(); t++;
            @(negedge i_clk);
        end
        chk("flush_regrant_cycle", t, 10);
        chk("flush_regrant_req0", o_req_ready, 4'b0001);
        chk("flush_idle", o_idle, 1);
        chk("flush_rsp_count", rsp_q.size(), 3);
        for (int j = 0; j < rsp_q.size(); j++) chk("flush_rsp_id", rsp_q[j].oh, 64'(2) << j);
        cyc(); i_req_valid = '0;
        repeat (8) cyc();

        // Dropped FPU valid: sticky error, response still follows the tag
        i_req_valid = 4'b0001;
        @(negedge i_clk); chk("drop_ready", o_req_ready, 4'b0001);
        cyc(); i_req_valid = '0;
        repeat (3) cyc();
        cyc(); fpu_drop = 1'b1;
        @(negedge i_clk); chk("drop_err_pre", o_err, 0);
        cyc(); fpu_drop = 1'b0;
        @(negedge i_clk);
        chk("drop_err", o_err, 1);
        chk("drop_rsp", {o_rsp_valid, o_rsp_data}, {4'b0001, 32'h4040_0000});
        repeat (3) cyc();
        @(negedge i_clk); chk("drop_err_sticky", o_err, 1);

        // Async reset mid-burst with ops in flight
        rsp_q.delete();
        cyc(); i_req_valid = '1;
        cyc();
        cyc(); #2 i_rst_n = 1'b0; #1;
        chk("arst_ready", o_req_ready, 0);
        chk("arst_fpu", {o_fpu_valid, o_fpu_op_a, o_fpu_op_b, o_fpu_sub}, 0);
        chk("arst_rsp", {o_rsp_valid, o_rsp_data}, 0);
        chk("arst_err_idle", {o_err, o_idle}, 2'b01);
        i_req_valid = '0;
        repeat (2) cyc();
        i_rst_n = 1'b1;
        repeat (10) cyc();
        chk("arst_no_rsp", rsp_q.size(), 0);
        chk("arst_quiet", {o_err, o_idle}, 2'b01);

        // req0 and req2 continuously valid
        for (int c = 0; c < 4; c++) begin
            cyc(); i_req_valid = 4'b0101;
            @(negedge i_clk);
`ifdef FPU_ARB_FIXED_PRIO_EN
            exp = 4'b0001;
`else
            exp = c[0] ? 4'b0100 : 4'b0001;
`endif
            chk("prio_grant", o_req_ready, exp);
        end
        cyc(); i_req_valid = '0;
        repeat (8) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_addsub_arbiter.md
Name: fpu_addsub_arbiter

Overview:
- Shares one fixed-latency, pipelined FPU add/sub datapath (align, add, normalize, round) among N requesters, typically FFT butterfly lanes.
- Picks one requester per cycle by round-robin and issues its operands to the FPU.
- Carries the requester ID down a tag pipeline that matches the FPU latency, then steers each result back as a one-hot response.
- Supports drain/flush sequencing for frame boundaries.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- SIZE_DATA, 32, IEEE-754 single operand/result width
- FPU_LATENCY, 4, cycles from issue to FPU result (>=1)
- SIZE_ID, 2, requester ID width, equal to clog2(NUM_REQ)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  NUM_REQ  per-requester operation valid
- i_req_op_a  in  NUM_REQ*SIZE_DATA  operand A; requester k occupies slice [k*SIZE_DATA +: SIZE_DATA]
- i_req_op_b  in  NUM_REQ*SIZE_DATA  operand B, same packing
- i_req_sub  in  NUM_REQ  1 = A-B, 0 = A+B
- o_req_ready  out  NUM_REQ  one-hot grant; handshake completes when valid and ready are both high
- o_fpu_valid  out  1  issue strobe to FPU
- o_fpu_op_a  out  SIZE_DATA  issued operand A
- o_fpu_op_b  out  SIZE_DATA  issued operand B
- o_fpu_sub  out  1  issued op select
- i_fpu_result  in  SIZE_DATA  FPU result, FPU_LATENCY cycles after issue
- i_fpu_valid  in  1  FPU result valid
- o_rsp_valid  out  NUM_REQ  one-hot response strobe
- o_rsp_data  out  SIZE_DATA  registered result
- i_flush  in  1  request drain
- o_idle  out  1  no ops in flight and state RUN
- o_err  out  1  sticky tag/valid mismatch flag

Behaviour:
- Reset values: o_req_ready=0, o_fpu_valid=0, o_fpu_op_a/b=0, o_fpu_sub=0, o_rsp_valid=0, o_rsp_data=0, o_err=0, o_idle=1. RR pointer=0, tag pipeline cleared, in-flight count=0, state=RUN.
- Grant (combinational, state RUN only):
  - Search valid requesters starting at the RR pointer, wrapping modulo NUM_REQ.
  - The first valid requester found gets o_req_ready.
  - No valid requester gives no grant.
- On handshake with requester g:
  - Next cycle, o_fpu_valid=1 and o_fpu_op_a/b/sub carry g's values (registered issue, 1 cycle).
  - RR pointer becomes (g+1) mod NUM_REQ.
  - Tag {1, g} enters the tag shift register.
- Tag pipeline: FPU_LATENCY stages, aligned to the issue register, so stage-out coincides with i_fpu_result.
- Response: at stage-out with tag valid, o_rsp_data<=i_fpu_result and o_rsp_valid<=onehot(id), both registered.
  - Total latency from handshake to o_rsp_valid is FPU_LATENCY+2 cycles.
  - Responses carry no backpressure; requesters must accept them.
- Error check: if i_fpu_valid differs from the stage-out tag valid in any cycle, o_err is set and stays set until reset. The response still follows the tag.
- In-flight count:
  - Increments on issue, decrements on response, with simultaneous events netting 0.
  - Range 0..FPU_LATENCY+1; it cannot overflow because at most one issue happens per cycle.
- State machine:
  - RUN -> DRAIN when i_flush=1. Grants are masked in the same cycle i_flush is sampled high.
  - DRAIN -> IDLE_WAIT when in-flight count reaches 0.
  - IDLE_WAIT -> RUN when i_flush=0.
  - While i_flush stays high, the block remains in IDLE_WAIT with the RR pointer reset to 0.
- o_idle=1 only when state=RUN and in-flight count=0.
- Reset mid-operation: all in-flight tags are discarded and no response is generated.

Optional Feature:
- Macro: FPU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The RR pointer register is removed.
- Undefined: round-robin as described above.
- Grant masking during DRAIN/IDLE_WAIT is unchanged in both modes.

Decomposition:
- Package fpu_arb_pkg holds:
  - typedef arb_state_e {RUN, DRAIN, IDLE_WAIT}
  - typedef tag_t struct {valid, id[SIZE_ID]}
  - function onehot_f(id)
- Sub-module fpu_arb_tag_pipe: parameterized delay line of tag_t, depth FPU_LATENCY, async active-low clear.

Test Plan:
- Single op: req0 valid A=0x3F800000, B=0x40000000, sub=0 -> ready0 in cycle 0; o_fpu_valid at cycle 1; FPU model returns 0x40400000; o_rsp_valid=0001 and o_rsp_data=0x40400000 at cycle FPU_LATENCY+2.
- All 4 valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; responses in the same order, one per cycle, 8 total.
- i_flush pulsed with 3 ops in flight and requests pending -> no grants while flushing; 3 responses still delivered; o_idle=1 after drain and i_flush deasserted; first new grant goes to req0.
- FPU model drops i_fpu_valid for one expected result -> o_err=1 sticky; response still emitted per tag.
- Async reset asserted mid-burst with 2 ops in flight -> all outputs at reset values immediately; no responses after release.
- With FPU_ARB_FIXED_PRIO_EN defined, req0 and req2 continuously valid -> req0 granted every cycle, req2 never.
